// File: rtl/icache_s2_nway_if.sv
// AXI read-address/read-data bundle between the I-cache refill engine and the bus.
interface icache_s2_nway_if;
  logic        axi_rd_req_o;
  logic [31:0] axi_rd_addr_o;
  logic [3:0]  axi_rd_len_o;
  logic        axi_rd_ack_i;
  logic        axi_rvalid_i;
  logic [31:0] axi_rdata_i;
  logic        axi_rlast_i;

  // Cache side issues the request and consumes the beats.
  modport master (
    output axi_rd_req_o, axi_rd_addr_o, axi_rd_len_o,
    input  axi_rd_ack_i, axi_rvalid_i, axi_rdata_i, axi_rlast_i
  );

  // Bus side accepts the request and returns the beats.
  modport slave (
    input  axi_rd_req_o, axi_rd_addr_o, axi_rd_len_o,
    output axi_rd_ack_i, axi_rvalid_i, axi_rdata_i, axi_rlast_i
  );
endinterface

// File: rtl/icache_s2_nway.sv
// I-cache stage 2: N-way tag compare with same-cycle hit data, AXI refill FSM on
// miss or uncached fetch, round-robin victim selection per set.
module icache_s2_nway #(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned INDEX_W    = 7,
  localparam int unsigned OFF_W     = $clog2(LINE_WORDS) + 2,
  localparam int unsigned TAG_W     = 32 - OFF_W - INDEX_W,
  localparam int unsigned WAY_W     = $clog2(WAYS),
  localparam int unsigned BEAT_W    = $clog2(LINE_WORDS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s2_req_i,
  input  logic [31:0]                s2_paddr_i,
  input  logic                       s2_cached_i,
  input  logic [WAYS*(TAG_W+1)-1:0]  s2_tagv_i,
  input  logic [WAYS*32-1:0]         s2_data_i,
  icache_s2_nway_if.master           axi,
  output logic                       wr_en_o,
  output logic [WAY_W-1:0]           wr_way_o,
  output logic [INDEX_W-1:0]         wr_index_o,
  output logic [TAG_W:0]             wr_tagv_o,
  output logic [LINE_WORDS*32-1:0]   wr_line_o,
  output logic                       stall_o,
  output logic                       rvalid_o,
  output logic [31:0]                rdata_o
);

  localparam int unsigned SETS = 1 << INDEX_W;

  typedef enum logic [2:0] {StIdle, StReq, StRecv, StInstall, StResp} state_e;

  state_e state_q, state_d;

  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_W-1:0]      req_idx;
  logic [BEAT_W-1:0]       req_off;

  logic [TAG_W-1:0]        tag_q;
  logic [INDEX_W-1:0]      idx_q;
  logic [BEAT_W-1:0]       off_q;
  logic                    cached_q;
  logic [WAY_W-1:0]        victim_q;
  logic [BEAT_W-1:0]       beat_q;
  logic                    full_q;
  logic [LINE_WORDS*32-1:0] line_q;
  logic [31:0]             crit_q;
  logic                    rd_req_q;
  logic [31:0]             rd_addr_q;
  logic [3:0]              rd_len_q;
  logic [WAY_W-1:0]        vptr_q [SETS];

  logic                    hit;
  logic [31:0]             hit_data;
  logic                    miss_start;
  logic                    beat_take;

  assign req_tag = s2_paddr_i[31 -: TAG_W];
  assign req_idx = s2_paddr_i[OFF_W+INDEX_W-1 : OFF_W];
  assign req_off = s2_paddr_i[OFF_W-1:2];

  assign axi.axi_rd_req_o  = rd_req_q;
  assign axi.axi_rd_addr_o = rd_addr_q;
  assign axi.axi_rd_len_o  = rd_len_q;

  // Beats are only accepted in RECV and until the slot counter has wrapped once.
  assign beat_take = (state_q == StRecv) && axi.axi_rvalid_i && !full_q;

  // Tag compare across all ways; walking downwards lets the lowest hitting way win.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (s2_tagv_i[w*(TAG_W+1) + TAG_W] &&
          (s2_tagv_i[w*(TAG_W+1) +: TAG_W] == req_tag)) begin
        hit      = 1'b1;
        hit_data = s2_data_i[w*32 +: 32];
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    miss_start = 1'b0;
    stall_o    = 1'b0;
    rvalid_o   = 1'b0;
    rdata_o    = '0;
    wr_en_o    = 1'b0;
    wr_way_o   = '0;
    wr_index_o = '0;
    wr_tagv_o  = '0;
    wr_line_o  = '0;
    case (state_q)
      StIdle: begin
        if (s2_req_i) begin
          if (s2_cached_i && hit) begin
            rvalid_o = 1'b1;
            rdata_o  = hit_data;
          end else begin
            stall_o    = 1'b1;
            miss_start = 1'b1;
            state_d    = StReq;
          end
        end
      end
      StReq: begin
        stall_o = 1'b1;
        if (axi.axi_rd_ack_i) state_d = StRecv;
      end
      StRecv: begin
        stall_o = 1'b1;
        if (axi.axi_rvalid_i && axi.axi_rlast_i) state_d = cached_q ? StInstall : StResp;
      end
      StInstall: begin
        stall_o    = 1'b1;
        wr_en_o    = 1'b1;
        wr_way_o   = victim_q;
        wr_index_o = idx_q;
        wr_tagv_o  = {1'b1, tag_q};
        wr_line_o  = line_q;
        state_d    = StResp;
      end
      StResp: begin
        rvalid_o = 1'b1;
        rdata_o  = crit_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Refill datapath: request latch, AXI address registers, line buffer and critical word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q     <= '0;
      idx_q     <= '0;
      off_q     <= '0;
      cached_q  <= 1'b0;
      victim_q  <= '0;
      beat_q    <= '0;
      full_q    <= 1'b0;
      line_q    <= '0;
      crit_q    <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_len_q  <= '0;
    end else begin
      if (miss_start) begin
        tag_q    <= req_tag;
        idx_q    <= req_idx;
        // Uncached fetches take beat 0 as the critical word.
        off_q    <= s2_cached_i ? req_off : '0;
        cached_q <= s2_cached_i;
        victim_q <= vptr_q[req_idx];
        beat_q   <= '0;
        full_q   <= 1'b0;
        line_q   <= '0;
        crit_q   <= '0;
        rd_req_q <= 1'b1;
        rd_addr_q <= s2_cached_i ? {s2_paddr_i[31:OFF_W], {OFF_W{1'b0}}} : s2_paddr_i;
        rd_len_q  <= s2_cached_i ? 4'(LINE_WORDS - 1) : 4'd0;
      end
      if ((state_q == StReq) && axi.axi_rd_ack_i) rd_req_q <= 1'b0;
      if (beat_take) begin
        line_q[beat_q*32 +: 32] <= axi.axi_rdata_i;
        if (beat_q == off_q) crit_q <= axi.axi_rdata_i;
        beat_q <= beat_q + BEAT_W'(1);
        if (beat_q == BEAT_W'(LINE_WORDS - 1)) full_q <= 1'b1;
      end
    end
  end

  // Per-set round-robin victim pointers; only an install advances them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SETS); s++) vptr_q[s] <= '0;
    end else if (state_q == StInstall) begin
      vptr_q[idx_q] <= vptr_q[idx_q] + WAY_W'(1);
    end
  end

endmodule

// File: doc/icache_s2_nway.md
# icache_s2_nway

Second stage of the instruction cache, parametrised in associativity, line length and index width. It does tag compare across all ways and returns hit data in the same cycle. On a miss or an uncached fetch it runs a refill FSM against the AXI read channel, and on cached misses it installs the line into a round-robin victim way. It sits between the stage-1 tag/data RAM read and the fetch stage, replacing the fixed 2-way stage.

## Interface
- `WAYS`, 2: associativity, power of two, 2..8.
- `LINE_WORDS`, 8: 32-bit words per line, power of two, 2..16; `OFF_W` = log2(`LINE_WORDS`)+2.
- `INDEX_W`, 7: set index bits; `TAG_W` = 32-`OFF_W`-`INDEX_W`.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset.
- `s2_req_i` in 1: fetch request valid; held stable with `s2_paddr_i`/`s2_cached_i` while `stall_o`=1.
- `s2_paddr_i` in 32: physical fetch address.
- `s2_cached_i` in 1: 1 = cached fetch, 0 = uncached.
- `s2_tagv_i` in `WAYS`*(`TAG_W`+1): per-way {valid, tag}, way 0 in the LSBs.
- `s2_data_i` in `WAYS`*32: per-way word at the fetch offset.
- `axi_rd_req_o` out 1: read address valid.
- `axi_rd_addr_o` out 32: read address.
- `axi_rd_len_o` out 4: beats-1.
- `axi_rd_ack_i` in 1: address accepted.
- `axi_rvalid_i` in 1: read data beat valid.
- `axi_rdata_i` in 32: read data beat.
- `axi_rlast_i` in 1: last beat.
- `wr_en_o` out 1: line install strobe.
- `wr_way_o` out log2(`WAYS`): way being installed.
- `wr_index_o` out `INDEX_W`: set being installed.
- `wr_tagv_o` out `TAG_W`+1: {1, tag} written with the line.
- `wr_line_o` out `LINE_WORDS`*32: line data, word 0 in the LSBs.
- `stall_o` out 1: pipeline stall.
- `rvalid_o` out 1: `rdata_o` valid this cycle.
- `rdata_o` out 32: instruction word.

## Operation
- Field split: tag = `paddr[31 -: TAG_W]`, index = `paddr[OFF_W+INDEX_W-1 : OFF_W]`, word offset = `paddr[OFF_W-1:2]`.
- Hit for way w: valid_w & (tag_w == tag). If more than one way hits, the lowest-numbered hitting way supplies data.
- FSM states: IDLE, REQ, RECV, INSTALL, RESP.
- IDLE:
  - `s2_req_i` & `s2_cached_i` & hit: `rvalid_o`=1, `rdata_o` = hitting way's word; stay in IDLE.
  - `s2_req_i` & (miss | !`s2_cached_i`): go to REQ and latch the address, cached flag and victim way.
- REQ: `axi_rd_req_o`=1. Cached: address = {`paddr[31:OFF_W]`, 0}, len = `LINE_WORDS`-1. Uncached: address = `paddr` unmodified, len = 0. Hold until `axi_rd_ack_i`, then go to RECV.
- RECV:
  - Each `axi_rvalid_i` beat is written to line buffer slot `beat_cnt`; `beat_cnt` (log2(`LINE_WORDS`) bits, cleared on entry) increments.
  - The beat whose index equals the word offset is captured as the critical word. For uncached fetches beat 0 is the critical word.
  - On a beat with `axi_rlast_i`: cached goes to INSTALL, uncached goes to RESP.
  - Beats after `beat_cnt` wraps are dropped. An early `rlast` ends the burst; unfilled slots are installed as 0.
- INSTALL: one cycle, `wr_en_o`=1, `wr_way_o` = latched victim, `wr_tagv_o` = {1, tag}. The victim pointer of that set increments modulo `WAYS`. Go to RESP.
- RESP: `rvalid_o`=1, `rdata_o` = critical word, `stall_o`=0; next state IDLE.
- Victim pointers: one log2(`WAYS`)-bit pointer per set (2^`INDEX_W` entries). They advance only on install; hits never move them.
- `stall_o` = (state ∈ {REQ, RECV, INSTALL}) | (IDLE & `s2_req_i` & !(`s2_cached_i` & hit)).
- `axi_rvalid_i` outside RECV is ignored.

## Timing
- Reset, synchronous on `rst_n`=0:
  - state = IDLE, `beat_cnt` = 0, all victim pointers = 0.
  - Every output is 0: `stall_o`, `rvalid_o`, `rdata_o`, `axi_rd_req_o`, `axi_rd_addr_o`, `axi_rd_len_o`, `wr_en_o`, `wr_way_o`, `wr_index_o`, `wr_tagv_o`, `wr_line_o`.
- Reset mid-refill aborts the refill with no install; any in-flight beats that arrive afterwards are ignored.
- Hit latency: 0 cycles (combinational from the stage-1 registers).
- Miss latency with ack on the first REQ cycle and back-to-back beats: 1 (REQ) + `LINE_WORDS` (RECV) + 1 (INSTALL) + 1 (RESP) cycles after the miss cycle.
- Uncached latency: 1 (REQ) + 1 (RECV) + 1 (RESP) under the same conditions.
- `axi_rd_req_o` and `axi_rd_addr_o` are registered outputs, stable from REQ entry until the ack cycle inclusive.
- `wr_*` outputs are valid only while `wr_en_o`=1; stage 1 must see the installed line on the cycle after INSTALL.

## Test plan
- Cold miss: WAYS=2, cached fetch 0x1FC0_0024 (all valid=0), 8 beats 0xA0..0xA7 → addr 0x1FC0_0020, len 7, install way 0 set 1, `rvalid_o` with `rdata_o`=0xA1 11 cycles after the request.
- Hit after install: same set/tag presented with valid way 0 and data 0xA5 at 0x1FC0_0034 → `rvalid_o`=1 and `rdata_o`=0xA5 in the same cycle, `stall_o`=0.
- Round robin: WAYS=4, three misses on set 3 with distinct tags → installs go to ways 0, 1, 2; a hit on set 3 does not move the pointer; the next miss uses way 3.
- Uncached: 0xBFC0_0008, `s2_cached_i`=0 → addr 0xBFC0_0008, len 0, `wr_en_o` never asserted, `rdata_o` = beat 0.
- Ack delay and early rlast: ack after 5 cycles → `axi_rd_req_o` held 5 cycles; `rlast` on beat 4 of 8 → slots 4–7 installed as 0.
- Reset on RECV beat 3 → the next cycle shows all outputs 0, no `wr_en_o`, and further beats are ignored.
